// File: rtl/wb_arb_pkg.sv
// Shared types for the register-file write-port arbiter.
// Optional feature macro used by the arbiter: WB_ARB_STARVE_EN.
package wb_arb_pkg;

    // Width of a register-file address (x0..x31).
    localparam int REG_ADDR_W = 5;

    // Data width carried by a buffered entry; the arbiter's XLEN defaults to this.
    localparam int WB_XLEN = 32;

    // One buffered long-latency result.
    typedef struct packed {
        logic                  valid;
        logic                  kill;
        logic [REG_ADDR_W-1:0] rd;
        logic [WB_XLEN-1:0]    data;
    } wb_entry_t;

    // Which source owns the write port this cycle.
    typedef enum logic [1:0] {
        SRC_NONE   = 2'd0,
        SRC_CORE   = 2'd1,
        SRC_BUF    = 2'd2,
        SRC_BYPASS = 2'd3
    } wb_src_e;

endpackage

// File: rtl/wb_arb_fifo.sv
// Two-entry FIFO of long-latency results with an rd-match kill port.
// A kill marks every buffered entry (and a same-cycle push) whose rd matches
// kill_rd; killed entries still pop normally so the caller can drop them.
import wb_arb_pkg::*;

module wb_arb_fifo #(
    parameter int XLEN = WB_XLEN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [REG_ADDR_W-1:0] push_rd,
    input  logic [XLEN-1:0]       push_data,
    input  logic                  pop,
    input  logic                  kill_en,
    input  logic [REG_ADDR_W-1:0] kill_rd,
    output wb_entry_t             head,
    output logic                  full,
    output logic                  empty
);

    wb_entry_t  r_mem [2];
    logic       r_head;
    logic [1:0] r_count;

    logic w_tail;
    logic w_push_ok;
    logic w_pop_ok;
    logic w_push_kill;

    // Tail slot is the head slot when empty, the other slot when one entry is held.
    assign w_tail      = r_head ^ r_count[0];
    assign w_push_ok   = push && (r_count != 2'd2);
    assign w_pop_ok    = pop && (r_count != 2'd0);
    assign w_push_kill = kill_en && (push_rd == kill_rd);

    assign head  = r_mem[r_head];
    assign full  = (r_count == 2'd2);
    assign empty = (r_count == 2'd0);

    // Storage, pointers and kill marking.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= 1'b0;
            r_count <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (r_mem[i].valid && kill_en && (r_mem[i].rd == kill_rd)) begin
                    r_mem[i].kill <= 1'b1;
                end
            end
            if (w_pop_ok) begin
                r_mem[r_head].valid <= 1'b0;
                r_head              <= ~r_head;
            end
            // Push never targets the head slot while a pop is in flight:
            // a push needs count<2 and a pop needs count>0, so tail != head then.
            if (w_push_ok) begin
                r_mem[w_tail] <= '{valid: 1'b1, kill: w_push_kill,
                                   rd: push_rd, data: push_data};
            end
            r_count <= r_count + {1'b0, w_push_ok} - {1'b0, w_pop_ok};
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter between the core write-back path and a
// long-latency unit (LU). Core writes always win; LU results either bypass
// straight to the port when it is free or wait in a 2-entry buffer.
// Macro WB_ARB_STARVE_EN enables the starvation counter that stalls the core
// for one cycle to force a buffer drain; without it core_stall is tied low.
//
// LU handshake: a result transfers on a cycle where lu_valid && lu_ready are
// both high; lu_ready depends only on buffer fullness and rst, never on
// lu_valid, and a transferred result is either written that cycle (bypass)
// or enqueued.
import wb_arb_pkg::*;

module wb_port_arbiter #(
    parameter int XLEN       = WB_XLEN,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  core_valid,
    input  logic [REG_ADDR_W-1:0] core_rd,
    input  logic [XLEN-1:0]       core_data,
    input  logic                  lu_valid,
    input  logic [REG_ADDR_W-1:0] lu_rd,
    input  logic [XLEN-1:0]       lu_data,
    output logic                  lu_ready,
    output logic                  core_stall,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_rd,
    output logic [XLEN-1:0]       rf_wdata
);

    wb_entry_t w_head;
    logic      w_full;
    logic      w_empty;
    logic      w_stall;
    logic      w_lu_fire;
    logic      w_pop;
    logic      w_push;
    logic      w_kill_en;
    wb_src_e   w_src;

    assign lu_ready  = !w_full && !rst;
    assign w_lu_fire = lu_valid && lu_ready;

    // Port owner: core (unless stalled), then buffer head, then LU bypass.
    always_comb begin
        w_src = SRC_NONE;
        if (core_valid && !w_stall) begin
            w_src = SRC_CORE;
        end else if (!w_empty) begin
            w_src = SRC_BUF;
        end else if (w_lu_fire) begin
            w_src = SRC_BYPASS;
        end
    end

    assign w_pop     = (w_src == SRC_BUF);
    assign w_push    = w_lu_fire && (w_src != SRC_BYPASS);
    // LU results are always older than the core write-back, so a core write
    // makes any buffered result to the same register dead.
    assign w_kill_en = (w_src == SRC_CORE) && (core_rd != '0);

    wb_arb_fifo #(
        .XLEN (XLEN)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_rd   (lu_rd),
        .push_data (lu_data),
        .pop       (w_pop),
        .kill_en   (w_kill_en),
        .kill_rd   (core_rd),
        .head      (w_head),
        .full      (w_full),
        .empty     (w_empty)
    );

    // Write-port mux; writes to x0 and killed entries are consumed silently.
    always_comb begin
        rf_we    = 1'b0;
        rf_rd    = '0;
        rf_wdata = '0;
        if (!rst) begin
            case (w_src)
                SRC_CORE: begin
                    rf_we    = (core_rd != '0);
                    rf_rd    = core_rd;
                    rf_wdata = core_data;
                end
                SRC_BUF: begin
                    rf_we    = !w_head.kill && (w_head.rd != '0);
                    rf_rd    = w_head.rd;
                    rf_wdata = w_head.data;
                end
                SRC_BYPASS: begin
                    rf_we    = (lu_rd != '0);
                    rf_rd    = lu_rd;
                    rf_wdata = lu_data;
                end
                default: begin
                    rf_we    = 1'b0;
                    rf_rd    = '0;
                    rf_wdata = '0;
                end
            endcase
        end
    end

`ifdef WB_ARB_STARVE_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] r_starve_cnt;
    logic             r_core_stall;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_cnt_inc = r_starve_cnt + CNT_W'(1);

    // Count core-won cycles while the buffer waits; on reaching the limit,
    // stall the core for exactly the next cycle so the head drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= '0;
            r_core_stall <= 1'b0;
        end else begin
            r_core_stall <= 1'b0;
            if (w_empty || w_pop) begin
                r_starve_cnt <= '0;
            end else if (w_src == SRC_CORE) begin
                if (w_cnt_inc == CNT_W'(STARVE_MAX)) begin
                    r_starve_cnt <= '0;
                    r_core_stall <= 1'b1;
                end else begin
                    r_starve_cnt <= w_cnt_inc;
                end
            end
        end
    end

    assign w_stall = r_core_stall;
`else
    assign w_stall = 1'b0;
`endif

    assign core_stall = w_stall;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: reset, bypass, core/LU conflict,
// backpressure, x0 writes, WAW kill, starvation drain and mid-run reset.
// Inputs change 1 time unit after the rising edge; outputs are checked 4
// units later, before the next edge.
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_valid;
    logic [4:0]  core_rd;
    logic [31:0] core_data;
    logic        lu_valid;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic        core_stall;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;

    int total = 0;
    int bad   = 0;

    // Clock: 10 time-unit period.
    always #5 clk = ~clk;

    wb_port_arbiter #(
        .XLEN       (32),
        .STARVE_MAX (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .core_valid (core_valid),
        .core_rd    (core_rd),
        .core_data  (core_data),
        .lu_valid   (lu_valid),
        .lu_rd      (lu_rd),
        .lu_data    (lu_data),
        .lu_ready   (lu_ready),
        .core_stall (core_stall),
        .rf_we      (rf_we),
        .rf_rd      (rf_rd),
        .rf_wdata   (rf_wdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full write-port check for a cycle that must write.
    task automatic chk_wr(input string tag, input logic [4:0] rd, input logic [31:0] data);
        chk({tag, ".we"}, {31'd0, rf_we}, 32'd1);
        chk({tag, ".rd"}, {27'd0, rf_rd}, {27'd0, rd});
        chk({tag, ".data"}, rf_wdata, data);
    endtask

    task automatic chk_nowr(input string tag);
        chk({tag, ".we"}, {31'd0, rf_we}, 32'd0);
    endtask

    task automatic drv(input logic cv, input logic [4:0] crd, input logic [31:0] cd,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
        core_valid = cv;
        core_rd    = crd;
        core_data  = cd;
        lu_valid   = lv;
        lu_rd      = lrd;
        lu_data    = ld;
    endtask

    task automatic idle();
        drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- reset ----------------
        rst = 1'b1;
        idle();
        repeat (2) tick();
        drv(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
        #4;
        chk("rst.we", {31'd0, rf_we}, 32'd0);
        chk("rst.rd", {27'd0, rf_rd}, 32'd0);
        chk("rst.data", rf_wdata, 32'd0);
        chk("rst.lu_ready", {31'd0, lu_ready}, 32'd0);
        chk("rst.stall", {31'd0, core_stall}, 32'd0);
        tick();
        rst = 1'b0;
        idle();
        #4;
        chk("post_rst.lu_ready", {31'd0, lu_ready}, 32'd1);
        chk("post_rst.stall", {31'd0, core_stall}, 32'd0);
        chk_nowr("post_rst");
        tick();

        // ---------------- bypass ----------------
        drv(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hA5);
        #4;
        chk_wr("bypass", 5'd5, 32'hA5);
        tick();
        idle();
        #4;
        chk_nowr("bypass.empty_after");
        chk("bypass.lu_ready", {31'd0, lu_ready}, 32'd1);
        tick();

        // ---------------- conflict ----------------
        drv(1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h22);
        #4;
        chk_wr("conflict.core", 5'd3, 32'h11);
        tick();
        idle();
        #4;
        chk_wr("conflict.lu", 5'd7, 32'h22);
        tick();
        idle();
        #4;
        chk_nowr("conflict.drained");
        tick();

        // ---------------- backpressure ----------------
        drv(1'b1, 5'd1, 32'h100, 1'b1, 5'd10, 32'hB0);
        #4;
        chk_wr("bp.c0", 5'd1, 32'h100);
        chk("bp.c0.lu_ready", {31'd0, lu_ready}, 32'd1);
        tick();
        drv(1'b1, 5'd2, 32'h200, 1'b1, 5'd11, 32'hB1);
        #4;
        chk_wr("bp.c1", 5'd2, 32'h200);
        chk("bp.c1.lu_ready", {31'd0, lu_ready}, 32'd1);
        tick();
        drv(1'b1, 5'd4, 32'h300, 1'b1, 5'd12, 32'hB2);
        #4;
        chk("bp.full.lu_ready", {31'd0, lu_ready}, 32'd0);
        chk_wr("bp.c2", 5'd4, 32'h300);
        tick();
        drv(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hB2);
        #4;
        chk("bp.still_full.lu_ready", {31'd0, lu_ready}, 32'd0);
        chk_wr("bp.pop0", 5'd10, 32'hB0);
        tick();
        drv(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hB2);
        #4;
        chk("bp.reassert.lu_ready", {31'd0, lu_ready}, 32'd1);
        chk_wr("bp.pop1", 5'd11, 32'hB1);
        tick();
        idle();
        #4;
        chk_wr("bp.pop2", 5'd12, 32'hB2);
        tick();
        idle();
        #4;
        chk_nowr("bp.drained");
        tick();

        // ---------------- x0 writes ----------------
        drv(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55);
        #4;
        chk_nowr("x0.bypass");
        tick();
        idle();
        #4;
        chk_nowr("x0.not_buffered");
        tick();
        drv(1'b1, 5'd0, 32'h66, 1'b0, 5'd0, 32'd0);
        #4;
        chk_nowr("x0.core");
        tick();

        // ---------------- WAW kill ----------------
        drv(1'b1, 5'd2, 32'h50, 1'b1, 5'd9, 32'h99);
        #4;
        chk_wr("waw.c0", 5'd2, 32'h50);
        tick();
        drv(1'b1, 5'd9, 32'h1, 1'b0, 5'd0, 32'd0);
        #4;
        chk_wr("waw.core9", 5'd9, 32'h1);
        tick();
        idle();
        #4;
        chk_nowr("waw.killed_pop");
        tick();
        idle();
        #4;
        chk_nowr("waw.consumed");
        tick();
        // Kill of an LU result accepted in the same cycle as the core write.
        drv(1'b1, 5'd13, 32'h77, 1'b1, 5'd13, 32'hEE);
        #4;
        chk_wr("waw_same.core", 5'd13, 32'h77);
        tick();
        idle();
        #4;
        chk_nowr("waw_same.killed_pop");
        tick();
        idle();
        #4;
        chk_nowr("waw_same.consumed");
        tick();

        // ---------------- starvation ----------------
        drv(1'b1, 5'd1, 32'h1000, 1'b1, 5'd20, 32'hC0);
        #4;
        chk_wr("starve.c0", 5'd1, 32'h1000);
        chk("starve.c0.stall", {31'd0, core_stall}, 32'd0);
        tick();
        for (int k = 1; k <= 4; k++) begin
            drv(1'b1, 5'(k + 1), 32'h1000 + 32'(k), 1'b0, 5'd0, 32'd0);
            #4;
            chk_wr("starve.core_won", 5'(k + 1), 32'h1000 + 32'(k));
            chk("starve.no_stall_yet", {31'd0, core_stall}, 32'd0);
            tick();
        end
`ifdef WB_ARB_STARVE_EN
        drv(1'b1, 5'd30, 32'hDEAD, 1'b0, 5'd0, 32'd0);
        #4;
        chk("starve.stall", {31'd0, core_stall}, 32'd1);
        chk_wr("starve.drain", 5'd20, 32'hC0);
        tick();
        drv(1'b1, 5'd31, 32'hBEEF, 1'b0, 5'd0, 32'd0);
        #4;
        chk("starve.stall_one_cycle", {31'd0, core_stall}, 32'd0);
        chk_wr("starve.core_resumes", 5'd31, 32'hBEEF);
        tick();
        idle();
        #4;
        chk_nowr("starve.drained");
        tick();
`else
        drv(1'b1, 5'd30, 32'hDEAD, 1'b0, 5'd0, 32'd0);
        #4;
        chk("nostarve.stall", {31'd0, core_stall}, 32'd0);
        chk_wr("nostarve.core_wins", 5'd30, 32'hDEAD);
        tick();
        idle();
        #4;
        chk_wr("nostarve.drain_when_idle", 5'd20, 32'hC0);
        tick();
        idle();
        #4;
        chk_nowr("nostarve.drained");
        tick();
`endif

        // ---------------- reset with two entries buffered ----------------
        drv(1'b1, 5'd1, 32'h2000, 1'b1, 5'd21, 32'hD1);
        tick();
        drv(1'b1, 5'd2, 32'h2001, 1'b1, 5'd22, 32'hD2);
        tick();
        idle();
        rst = 1'b1;
        #4;
        chk_nowr("mid_rst");
        chk("mid_rst.lu_ready", {31'd0, lu_ready}, 32'd0);
        tick();
        rst = 1'b0;
        idle();
        #4;
        chk("after_rst.lu_ready", {31'd0, lu_ready}, 32'd1);
        chk("after_rst.stall", {31'd0, core_stall}, 32'd0);
        chk_nowr("after_rst.empty");
        tick();
        idle();
        #4;
        chk_nowr("after_rst.empty2");
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
